// File: rtl/btn_conditioner.sv
// Pushbutton synchroniser, debouncer and tick generator.
// Emits press ticks, hold-to-repeat ticks and an any-key press strobe.
module btn_conditioner #(
  parameter int NUM_BTNS = 4,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_PERIOD = 3125000,
  parameter logic [NUM_BTNS-1:0] REPEAT_MASK =
    NUM_BTNS'(4'b0011)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_tick,
  output logic [NUM_BTNS-1:0] btn_press_tick,
  output logic                any_press_tick
);

  localparam int MAX_A =
    (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
    DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_P =
    (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_P);

  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST =
    CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST =
    CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } state_e;

  logic [NUM_BTNS-1:0] p_in;
  logic [NUM_BTNS-1:0] p1;
  logic [NUM_BTNS-1:0] p2;

  // p=1 means pressed regardless of board polarity
  assign p_in = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= p_in;
      p2 <= p1;
    end
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    state_e        st;
    state_e        st_n;
    logic [CW-1:0] db;
    logic [CW-1:0] db_n;
    logic [CW-1:0] rep;
    logic [CW-1:0] rep_n;
    logic          fd;
    logic          fd_n;
    logic          lvl_q;
    logic          lvl_n;
    logic          tk_q;
    logic          tk_n;
    logic          pt_q;
    logic          pt_n;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st    <= RELEASED;
        db    <= '0;
        rep   <= '0;
        fd    <= 1'b0;
        lvl_q <= 1'b0;
        tk_q  <= 1'b0;
        pt_q  <= 1'b0;
      end else begin
        st    <= st_n;
        db    <= db_n;
        rep   <= rep_n;
        fd    <= fd_n;
        lvl_q <= lvl_n;
        tk_q  <= tk_n;
        pt_q  <= pt_n;
      end
    end

    always_comb begin
      st_n  = st;
      db_n  = db;
      rep_n = rep;
      fd_n  = fd;
      lvl_n = lvl_q;
      tk_n  = 1'b0;
      pt_n  = 1'b0;
      unique case (st)
        RELEASED: begin
          if (p2[i]) begin
            st_n = PRESS_DB;
            db_n = '0;
          end
        end
        PRESS_DB: begin
          if (!p2[i]) begin
            st_n = RELEASED;
            db_n = '0;
          end else if (db == DB_LAST) begin
            st_n  = PRESSED;
            db_n  = '0;
            lvl_n = 1'b1;
            tk_n  = 1'b1;
            pt_n  = 1'b1;
            rep_n = '0;
            fd_n  = 1'b0;
          end else begin
            db_n = db + 1'b1;
          end
        end
        PRESSED: begin
          if (!p2[i]) begin
            st_n = RELEASE_DB;
            db_n = '0;
          end else if (REPEAT_MASK[i]) begin
            if (rep == (fd ? PER_LAST : DLY_LAST)) begin
              tk_n  = 1'b1;
              rep_n = '0;
              fd_n  = 1'b1;
            end else begin
              rep_n = rep + 1'b1;
            end
          end else begin
            rep_n = '0;
          end
        end
        RELEASE_DB: begin
          // rep/fd stay frozen so a glitch only delays repeats
          if (p2[i]) begin
            st_n = PRESSED;
            db_n = '0;
          end else if (db == DB_LAST) begin
            st_n  = RELEASED;
            db_n  = '0;
            lvl_n = 1'b0;
            rep_n = '0;
            fd_n  = 1'b0;
          end else begin
            db_n = db + 1'b1;
          end
        end
        default: begin
          st_n = RELEASED;
        end
      endcase
    end

    assign btn_level[i]      = lvl_q;
    assign btn_tick[i]       = tk_q;
    assign btn_press_tick[i] = pt_q;
  end

  assign any_press_tick = |btn_press_tick;

endmodule
